// File: rtl/cpu_pkg.sv
// Shared CPU definitions: address-mux select codes, exception cause codes,
// exception sequencer state encoding and the fixed vector slot addresses.
package cpu_pkg;

   localparam logic [2:0] ASEL_PC      = 3'b000;
   localparam logic [2:0] ASEL_VEC_OPC = 3'b100;
   localparam logic [2:0] ASEL_VEC_OVF = 3'b101;
   localparam logic [2:0] ASEL_VEC_DIV = 3'b110;

   localparam logic [7:0] VEC_ADDR_OPC = 8'd253;
   localparam logic [7:0] VEC_ADDR_OVF = 8'd254;
   localparam logic [7:0] VEC_ADDR_DIV = 8'd255;

   typedef enum logic [1:0] {
      CAUSE_NONE = 2'd0,
      CAUSE_OPC  = 2'd1,
      CAUSE_OVF  = 2'd2,
      CAUSE_DIV  = 2'd3
   } cause_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SAVE = 2'd1,
      ST_WAIT = 2'd2,
      ST_LOAD = 2'd3
   } exc_state_e;

   // Map a cause onto the vector slot the address mux must select.
   function automatic logic [2:0] asel_for_cause(input cause_e c);
      logic [2:0] sel;
      case (c)
         CAUSE_OPC: sel = ASEL_VEC_OPC;
         CAUSE_OVF: sel = ASEL_VEC_OVF;
         CAUSE_DIV: sel = ASEL_VEC_DIV;
         default:   sel = ASEL_PC;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/exception_vector_ctrl.sv
// Exception sequencer: saves EPC, selects the vector slot for the cause,
// waits out memory latency and loads the PC with the handler address.
module exception_vector_ctrl
   import cpu_pkg::*;
#(
   parameter int unsigned MEM_WAIT = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        exc_opcode,
   input  logic        exc_overflow,
   input  logic        exc_div0,
   input  logic [31:0] pc_in,
   input  logic [31:0] mem_data_in,
   output logic [2:0]  addr_sel,
   output logic        busy,
   output logic        epc_write,
   output logic [31:0] epc_out,
   output logic        pc_write,
   output logic [31:0] pc_out,
   output logic [1:0]  cause
);

   localparam logic [2:0]  WAIT_LOAD    = 3'(MEM_WAIT - 1);
   localparam logic [31:0] HANDLER_MASK = 32'h0000_00FF;

   exc_state_e  state_r, state_nx;
   logic [2:0]  cnt_r, cnt_nx;
   logic [2:0]  addr_sel_r, addr_sel_nx;
   logic        busy_r, busy_nx;
   logic        epc_write_r, epc_write_nx;
   logic        pc_write_r, pc_write_nx;
   logic [31:0] epc_out_r, epc_out_nx;
   logic [31:0] pc_out_r, pc_out_nx;
   cause_e      cause_r, cause_nx;
   cause_e      exc_cause_s;

   // Next-state and next-output logic; outputs are computed one edge ahead
   // so that every strobe lands in the state it belongs to.
   always_comb begin
      state_nx     = state_r;
      cnt_nx       = cnt_r;
      addr_sel_nx  = addr_sel_r;
      busy_nx      = busy_r;
      epc_write_nx = 1'b0;
      pc_write_nx  = 1'b0;
      epc_out_nx   = epc_out_r;
      pc_out_nx    = pc_out_r;
      cause_nx     = cause_r;

      if (exc_opcode) begin
         exc_cause_s = CAUSE_OPC;
      end else if (exc_overflow) begin
         exc_cause_s = CAUSE_OVF;
      end else if (exc_div0) begin
         exc_cause_s = CAUSE_DIV;
      end else begin
         exc_cause_s = CAUSE_NONE;
      end

      case (state_r)
         ST_IDLE: begin
            if (exc_cause_s != CAUSE_NONE) begin
               state_nx     = ST_SAVE;
               cause_nx     = exc_cause_s;
               addr_sel_nx  = asel_for_cause(exc_cause_s);
               busy_nx      = 1'b1;
               epc_write_nx = 1'b1;
               epc_out_nx   = pc_in - 32'd4;
            end else begin
               addr_sel_nx = ASEL_PC;
               busy_nx     = 1'b0;
            end
         end
         ST_SAVE: begin
            cnt_nx   = WAIT_LOAD;
            state_nx = ST_WAIT;
         end
         ST_WAIT: begin
            if (cnt_r == 3'd0) begin
               state_nx    = ST_LOAD;
               pc_write_nx = 1'b1;
               pc_out_nx   = mem_data_in & HANDLER_MASK;
            end else begin
               cnt_nx = cnt_r - 3'd1;
            end
         end
         ST_LOAD: begin
            state_nx    = ST_IDLE;
            addr_sel_nx = ASEL_PC;
            busy_nx     = 1'b0;
         end
         default: begin
            state_nx    = ST_IDLE;
            cnt_nx      = 3'd0;
            addr_sel_nx = ASEL_PC;
            busy_nx     = 1'b0;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r     <= ST_IDLE;
         cnt_r       <= 3'd0;
         addr_sel_r  <= ASEL_PC;
         busy_r      <= 1'b0;
         epc_write_r <= 1'b0;
         pc_write_r  <= 1'b0;
         epc_out_r   <= 32'd0;
         pc_out_r    <= 32'd0;
         cause_r     <= CAUSE_NONE;
      end else begin
         state_r     <= state_nx;
         cnt_r       <= cnt_nx;
         addr_sel_r  <= addr_sel_nx;
         busy_r      <= busy_nx;
         epc_write_r <= epc_write_nx;
         pc_write_r  <= pc_write_nx;
         epc_out_r   <= epc_out_nx;
         pc_out_r    <= pc_out_nx;
         cause_r     <= cause_nx;
      end
   end

   assign addr_sel  = addr_sel_r;
   assign busy      = busy_r;
   assign epc_write = epc_write_r;
   assign epc_out   = epc_out_r;
   assign pc_write  = pc_write_r;
   assign pc_out    = pc_out_r;
   assign cause     = cause_r;

endmodule

// File: tb/tb_exception_vector_ctrl.sv
// Bench for exception_vector_ctrl: directed vector table, hand-written
// corner sequences and random traffic against a timeline reference model.
module tb_exception_vector_ctrl;

   localparam int MW = 2;

   logic        clk;
   logic        reset_n;
   logic        exc_opcode, exc_overflow, exc_div0;
   logic [31:0] pc_in;
   logic [31:0] mem_data_in;
   logic [2:0]  addr_sel;
   logic        busy, epc_write, pc_write;
   logic [31:0] epc_out, pc_out;
   logic [1:0]  cause;

   exception_vector_ctrl #(.MEM_WAIT(MW)) dut (
      .clk(clk), .reset_n(reset_n),
      .exc_opcode(exc_opcode), .exc_overflow(exc_overflow), .exc_div0(exc_div0),
      .pc_in(pc_in), .mem_data_in(mem_data_in),
      .addr_sel(addr_sel), .busy(busy), .epc_write(epc_write), .epc_out(epc_out),
      .pc_write(pc_write), .pc_out(pc_out), .cause(cause)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Vector memory: slot contents for 253 / 254 / 255.
   logic [31:0] slot [3];
   always_comb begin
      mem_data_in = 32'h0;
      case (addr_sel)
         3'b100:  mem_data_in = slot[0];
         3'b101:  mem_data_in = slot[1];
         3'b110:  mem_data_in = slot[2];
         default: mem_data_in = 32'h0;
      endcase
   end

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Reference model: a sequence started at edge s is a fixed timeline.
   int          e = 0;
   int          s = 0;
   bit          active = 0;
   logic [1:0]  m_cause = 2'd0;
   logic [31:0] m_epc = 32'd0;

   // Per-sequence observations.
   int          n_epc, n_pcw, n_sel;
   logic [31:0] last_epc, last_pco;
   logic [2:0]  save_sel;

   function automatic logic [1:0] prio(input logic [2:0] x);
      for (int i = 0; i < 3; i++) if (x[i]) return 2'(i + 1);
      return 2'd0;
   endfunction

   task automatic model_reset();
      active  = 0;
      m_cause = 2'd0;
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_asel"},  {29'd0, addr_sel}, 32'd0);
      chk({tag, "_busy"},  {31'd0, busy}, 32'd0);
      chk({tag, "_epcw"},  {31'd0, epc_write}, 32'd0);
      chk({tag, "_pcw"},   {31'd0, pc_write}, 32'd0);
      chk({tag, "_epc"},   epc_out, 32'd0);
      chk({tag, "_pco"},   pc_out, 32'd0);
      chk({tag, "_cause"}, {30'd0, cause}, 32'd0);
   endtask

   // exc bit0 = opcode, bit1 = overflow, bit2 = div0.
   task automatic step(input logic [2:0] exc, input logic [31:0] pc);
      int d;
      bit on;
      logic [2:0] exp_sel;
      exc_opcode   = exc[0];
      exc_overflow = exc[1];
      exc_div0     = exc[2];
      pc_in        = pc;
      @(posedge clk);
      e++;
      if (active && (e - s) >= MW + 3) active = 0;
      if (!active && exc != 3'b000) begin
         active  = 1;
         s       = e;
         m_cause = prio(exc);
         m_epc   = pc - 32'd4;
      end
      @(negedge clk);
      d  = e - s;
      on = active && d <= MW + 1;
      exp_sel = on ? 3'(3 + m_cause) : 3'b000;
      chk("busy",  {31'd0, busy}, {31'd0, on});
      chk("asel",  {29'd0, addr_sel}, {29'd0, exp_sel});
      chk("epcw",  {31'd0, epc_write}, {31'd0, on && d == 0});
      chk("pcw",   {31'd0, pc_write}, {31'd0, on && d == MW + 1});
      chk("cause", {30'd0, cause}, {30'd0, m_cause});
      if (on && d == 0) chk("epc", epc_out, m_epc);
      if (on && d == MW + 1) chk("pco", pc_out, {24'd0, slot[m_cause - 2'd1][7:0]});
      if (epc_write) begin n_epc++; last_epc = epc_out; save_sel = addr_sel; end
      if (pc_write)  begin n_pcw++; last_pco = pc_out; end
      if (busy && addr_sel == save_sel) n_sel++;
   endtask

   task automatic clear_obs();
      n_epc = 0; n_pcw = 0; n_sel = 0;
      last_epc = 32'hx; last_pco = 32'hx; save_sel = 3'b111;
   endtask

   typedef struct {
      logic [2:0]  exc;
      logic [31:0] pc;
      logic [31:0] mem;
      logic [2:0]  asel;
      logic [1:0]  cse;
      logic [31:0] epc;
      logic [31:0] pco;
   } vec_t;

   vec_t vecs[5];

   initial begin
      vecs[0] = '{3'b010, 32'h0000_0040, 32'h0000_00A0, 3'b101, 2'd2, 32'h0000_003C, 32'h0000_00A0};
      vecs[1] = '{3'b111, 32'h0000_1000, 32'h1234_5678, 3'b100, 2'd1, 32'h0000_0FFC, 32'h0000_0078};
      vecs[2] = '{3'b100, 32'h0000_0000, 32'hDEAD_BEEF, 3'b110, 2'd3, 32'hFFFF_FFFC, 32'h0000_00EF};
      vecs[3] = '{3'b101, 32'h8000_0000, 32'hFFFF_FF01, 3'b100, 2'd1, 32'h7FFF_FFFC, 32'h0000_0001};
      vecs[4] = '{3'b110, 32'h0000_0004, 32'h0000_0055, 3'b101, 2'd2, 32'h0000_0000, 32'h0000_0055};

      exc_opcode = 1'b0; exc_overflow = 1'b0; exc_div0 = 1'b0;
      pc_in = 32'd0;
      for (int i = 0; i < 3; i++) slot[i] = 32'h0;

      // Reset and ten quiet cycles.
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_values("rst");
      reset_n = 1'b1;
      clear_obs();
      for (int i = 0; i < 10; i++) step(3'b000, 32'h100);
      chk("rst_idle_epcw_cnt", n_epc, 0);
      chk("rst_idle_pcw_cnt",  n_pcw, 0);

      // Directed table.
      for (int v = 0; v < 5; v++) begin
         for (int i = 0; i < 3; i++) slot[i] = vecs[v].mem;
         clear_obs();
         step(vecs[v].exc, vecs[v].pc);
         for (int i = 0; i < MW + 3; i++) step(3'b000, 32'h0);
         chk($sformatf("v%0d_asel", v),  {29'd0, save_sel}, {29'd0, vecs[v].asel});
         chk($sformatf("v%0d_cause", v), {30'd0, cause}, {30'd0, vecs[v].cse});
         chk($sformatf("v%0d_epc", v),   last_epc, vecs[v].epc);
         chk($sformatf("v%0d_pco", v),   last_pco, vecs[v].pco);
         chk($sformatf("v%0d_nepc", v),  n_epc, 1);
         chk($sformatf("v%0d_npcw", v),  n_pcw, 1);
         chk($sformatf("v%0d_nsel", v),  n_sel, MW + 2);
      end

      // Div0 during WAIT of an opcode exception is dropped.
      slot[0] = 32'h0000_0011; slot[1] = 32'h0000_0022; slot[2] = 32'h0000_0033;
      clear_obs();
      step(3'b001, 32'h200);
      step(3'b000, 32'h0);
      for (int i = 0; i < MW + 1; i++) step(3'b100, 32'h300);
      step(3'b000, 32'h0);
      chk("ign_cause", {30'd0, cause}, 32'd1);
      chk("ign_nepc", n_epc, 1);
      chk("ign_npcw", n_pcw, 1);
      clear_obs();
      step(3'b100, 32'h400);
      chk("ign_next_asel", {29'd0, addr_sel}, 32'b110);
      for (int i = 0; i < MW + 2; i++) step(3'b000, 32'h0);
      chk("ign_next_pco", last_pco, 32'h33);

      // Reset during WAIT: immediate idle, no PC write afterwards.
      clear_obs();
      step(3'b001, 32'h500);
      step(3'b000, 32'h0);
      #2 reset_n = 1'b0;
      #1;
      chk("midrst_asel", {29'd0, addr_sel}, 32'd0);
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      model_reset();
      repeat (2) begin
         @(negedge clk);
         chk("midrst_hold_pcw", {31'd0, pc_write}, 32'd0);
      end
      check_reset_values("midrst");
      reset_n = 1'b1;
      clear_obs();
      for (int i = 0; i < 10; i++) step(3'b000, 32'h0);
      chk("midrst_npcw", n_pcw, 0);

      // Exception coincident with reset release is taken on the first edge.
      reset_n = 1'b0;
      @(negedge clk);
      model_reset();
      reset_n = 1'b1;
      clear_obs();
      step(3'b010, 32'h0000_0600);
      chk("rel_epcw", {31'd0, epc_write}, 32'd1);
      chk("rel_epc", epc_out, 32'h0000_05FC);
      for (int i = 0; i < MW + 2; i++) step(3'b000, 32'h0);

      // Random traffic against the model.
      for (int i = 0; i < 3; i++) slot[i] = $urandom;
      for (int i = 0; i < 400; i++) begin
         logic [2:0] x;
         x[0] = ($urandom_range(0, 5) == 0);
         x[1] = ($urandom_range(0, 5) == 0);
         x[2] = ($urandom_range(0, 5) == 0);
         step(x, $urandom);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/exception_vector_ctrl.md
# exception_vector_ctrl

Multicycle exception sequencer for the processor datapath. It latches invalid-opcode, arithmetic-overflow and divide-by-zero events, saves the faulting PC into EPC, and drives the 3-bit memory-address selector to the vector slot for the cause (253/254/255). It then waits out memory latency and loads the PC with the handler address read from that slot. It is the control end of the address-select mux: the mux decodes `addr_sel`, and this block generates it.

## Interface
- `MEM_WAIT`, default 2: cycles from `addr_sel` change to valid `mem_data_in`; legal range 1–7.
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `exc_opcode` input 1: invalid opcode detected; one-cycle pulse or level.
- `exc_overflow` input 1: ALU overflow on a signed op.
- `exc_div0` input 1: divide-by-zero from the divider.
- `pc_in` input 32: current PC, already incremented (faulting instr + 4).
- `mem_data_in` input 32: memory read data; the low byte is the handler address.
- `addr_sel` output 3: selector to the address mux. 3'b000 = normal PC path, 3'b100 = 253, 3'b101 = 254, 3'b110 = 255.
- `busy` output 1: this block owns `addr_sel`, PC and EPC writes; main control stalls.
- `epc_write` output 1: one-cycle EPC load strobe.
- `epc_out` output 32: value for EPC, valid while `epc_write` = 1.
- `pc_write` output 1: one-cycle PC load strobe.
- `pc_out` output 32: handler address, valid while `pc_write` = 1.
- `cause` output 2: 0 none, 1 opcode, 2 overflow, 3 div0. Held until the next exception is taken.

## Operation
- FSM states: IDLE, SAVE, WAIT, LOAD.
- IDLE:
  - `addr_sel` = 000 and `busy` = 0.
  - When any `exc_*` input is 1, go to SAVE and latch the cause by fixed priority: opcode > overflow > div0.
  - Also latch `pc_in` in the same cycle.
- SAVE (1 cycle):
  - `busy` = 1, `epc_write` = 1, `epc_out` = latched PC − 32'd4, modulo 2^32. A latched PC of 0 gives 0xFFFFFFFC.
  - `addr_sel` = code for the latched cause.
  - Load the wait counter with `MEM_WAIT` − 1. Go to WAIT.
- WAIT:
  - Hold `addr_sel` and decrement the counter.
  - At count 0 go to LOAD.
  - If `MEM_WAIT` = 1, WAIT lasts exactly 1 cycle.
- LOAD (1 cycle):
  - `pc_write` = 1, `pc_out` = {24'b0, `mem_data_in`[7:0]}; the upper bytes are ignored.
  - `addr_sel` is still held. Go to IDLE.
- Exception inputs asserted in any state other than IDLE are ignored; there is no nesting and nothing is queued.
- `cause` updates only on the IDLE→SAVE transition.

## Timing
- Reset values:
  - Reset asserted forces IDLE immediately, asynchronously, at any state including mid-sequence.
  - Outputs on reset: `addr_sel` = 000, `busy` = 0, `epc_write` = 0, `pc_write` = 0, `epc_out` = 0, `pc_out` = 0, `cause` = 0, counter = 0.
  - No partial EPC or PC write occurs after reset is asserted.
- Latency:
  - Exception sampled at edge N.
  - SAVE occupies cycle N+1 (`epc_write` high).
  - WAIT occupies cycles N+2 … N+1+`MEM_WAIT`.
  - LOAD (`pc_write` high) occurs at cycle N+2+`MEM_WAIT`.
  - IDLE resumes at N+3+`MEM_WAIT`. Total `busy` time = `MEM_WAIT` + 2 cycles.
- Output timing:
  - All outputs are registered.
  - `addr_sel` is stable from SAVE through LOAD inclusive.
  - The earliest new exception accepted is in the first IDLE cycle after LOAD.
- Simultaneous events:
  - Several `exc_*` inputs high in the same cycle: only the highest-priority one is taken.
  - An exception together with the deassertion of reset: it is sampled on the first edge with `reset_n` = 1.

## Structure
- Shared package `cpu_pkg` holds:
  - the `addr_sel` encodings (`ASEL_PC`, `ASEL_VEC_OPC`, `ASEL_VEC_OVF`, `ASEL_VEC_DIV`);
  - the cause codes;
  - the FSM state enum.
- The vector addresses 253/254/255 live in the same package, for the mux and for benches.
- Single module, no sub-modules. The wait counter is a 3-bit register inside the block.

## Test plan
- Reset:
  - Stimulus: `reset_n` = 0, then release.
  - Check: all outputs at reset values, `addr_sel` = 000, and no strobes for 10 idle cycles.
- Overflow:
  - Stimulus: `exc_overflow` pulse, `pc_in` = 0x00000040, `MEM_WAIT` = 2, memory returns 0x000000A0.
  - Check: `epc_write` with `epc_out` = 0x0000003C one cycle later.
  - Check: `addr_sel` = 101 for 4 cycles.
  - Check: `pc_write` with `pc_out` = 0x000000A0; `cause` = 2.
- Priority:
  - Stimulus: `exc_opcode`, `exc_overflow` and `exc_div0` high together.
  - Check: `addr_sel` = 100, `cause` = 1, exactly one `epc_write` and one `pc_write`.
- Ignore while busy:
  - Stimulus: `exc_div0` during WAIT of an opcode exception.
  - Check: no second sequence; `cause` stays 1; the next `exc_div0` after IDLE gives `addr_sel` = 110.
- Wrap and masking:
  - Stimulus: `pc_in` = 0x00000000 with `exc_div0`; memory returns 0xDEADBEEF.
  - Check: `epc_out` = 0xFFFFFFFC, `pc_out` = 0x000000EF.
- Reset mid-sequence:
  - Stimulus: `reset_n` = 0 during WAIT.
  - Check: immediate `addr_sel` = 000 and `busy` = 0; no `pc_write` ever follows.
